pipe_adder_sv: RTL

//   Parametrised, pipelined two-operand adder with valid/ready handshake.

---
 rtl/pipe_adder_sv.sv | 60 ++++++
 1 files changed

// File: rtl/pipe_adder_sv.sv
// pipe_adder_sv: pipelined two-operand adder with valid/ready handshake, signed/saturating modes and carry/overflow flags.
// A single global enable (adv) moves every stage at once, so bubbles keep their slots.
module pipe_adder_sv #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_0,
    input  logic [W-1:0] x_1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf
);
    logic              adv;
    logic [W:0]        raw;
    logic              ovf_c;
    logic [W-1:0]      res_c;
    logic [STAGES-1:0] v_q, c_q, o_q;
    logic [W-1:0]      r_q [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign raw      = {1'b0, x_0} + {1'b0, x_1};
    assign ovf_c    = (SIGNED != 0) ? (x_0[W-1] == x_1[W-1]) && (raw[W-1] != x_0[W-1]) : raw[W];
    // Signed overflow only happens with equal operand signs, so x_0's sign picks the clamp rail.
    assign res_c    = (SAT == 0 || !ovf_c) ? raw[W-1:0] :
                      (SIGNED == 0) ? {W{1'b1}} : {x_0[W-1], {(W-1){!x_0[W-1]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            o_q <= '0;
            for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            r_q[0] <= res_c;
            c_q[0] <= raw[W];
            o_q[0] <= ovf_c;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                r_q[i] <= r_q[i-1];
                c_q[i] <= c_q[i-1];
                o_q[i] <= o_q[i-1];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign result    = r_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];
endmodule
